// File: rtl/codel_dequeue_ctrl_pkg.sv
// CoDel dequeue controller shared types, sizes and the reciprocal-sqrt generator.
// Imported by the controller top and its inverse-sqrt ROM.
package CodelPkg;
  localparam int NUM_QUEUES      = 8;
  localparam int TIME_W          = 32;
  localparam int QLEN_W          = 16;
  localparam int COUNT_W         = 16;
  localparam int LUT_ADDR_W      = 6;
  localparam int INV_SQRT_FRAC_W = 16;
  localparam int QID_W           = $clog2(NUM_QUEUES);
  localparam int LUT_ENTRIES     = 2 ** LUT_ADDR_W;

  typedef logic [TIME_W-1:0]          TimeCtr;
  typedef logic [QLEN_W-1:0]          QueueLength;
  typedef logic [QID_W-1:0]           QueueId;
  typedef logic [COUNT_W-1:0]         DropCount;
  typedef logic [INV_SQRT_FRAC_W-1:0] InvSqrt;
  typedef logic [LUT_ADDR_W-1:0]      LutAddr;
  typedef logic [TIME_W+INV_SQRT_FRAC_W-1:0] CtrlProd;

  localparam QueueLength MAX_PACKET = QueueLength'(1500);

  typedef enum logic {
    IDLE     = 1'b0,
    DROPPING = 1'b1
  } CodelMode;

  typedef struct packed {
    TimeCtr   first_above;
    TimeCtr   drop_next;
    DropCount count;
    CodelMode dropping;
  } CodelQState;

  // Wrap-safe "a >= b" on the modular time line.
  function automatic logic time_ge(input TimeCtr a, input TimeCtr b);
    TimeCtr d;
    d = a - b;
    return ~d[TIME_W-1];
  endfunction

  // floor(2^F / sqrt(c)) by integer search, clamped to the Q0.F range.
  function automatic InvSqrt inv_sqrt_q16(input int unsigned c);
    longint unsigned lo, hi, mid, one, lim;
    one = 64'd1 << INV_SQRT_FRAC_W;
    lim = 64'd1 << (2 * INV_SQRT_FRAC_W);
    lo  = 0;
    hi  = one;
    for (int i = 0; i < INV_SQRT_FRAC_W + 2; i++) begin
      mid = (lo + hi + 1) >> 1;
      if (mid * mid * longint'(c) <= lim) lo = mid;
      else hi = mid - 1;
    end
    if (lo > one - 1) lo = one - 1;
    return InvSqrt'(lo);
  endfunction
endpackage

// File: rtl/codel_dequeue_ctrl_inv_sqrt_lut.sv
// Combinational Q0.16 reciprocal-sqrt ROM; addr k holds 1/sqrt(k+1).
// Ports: addr (count-1), data (Q0.16 value).
module codel_inv_sqrt_lut
  import CodelPkg::*;
(
  input  LutAddr addr,
  output InvSqrt data
);
  InvSqrt rom [LUT_ENTRIES];

  for (genvar g = 0; g < LUT_ENTRIES; g++) begin : g_rom
    localparam InvSqrt V = inv_sqrt_q16(g + 1);
    assign rom[g] = V;
  end

  assign data = rom[addr];
endmodule

// File: rtl/codel_dequeue_ctrl.sv
// Multi-queue CoDel dequeue drop controller with full control law, latency 1.
// Ports: deq request (queue id, head stamp, length, time, target, interval) -> drop decision.
module codel_dequeue_ctrl
  import CodelPkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i__deq_valid,
  input  QueueId     i__queue_id,
  input  logic       i__packet_null,
  input  TimeCtr     i__packet_time_stamp,
  input  QueueLength i__queue_length,
  input  TimeCtr     i__time_counter,
  input  TimeCtr     i__target,
  input  TimeCtr     i__interval,
  output logic       o__valid,
  output QueueId     o__queue_id,
  output logic       o__drop,
  output logic       o__dropping,
  output DropCount   o__count
);
  CodelQState st_q [NUM_QUEUES];
  CodelQState cur, nxt;

  TimeCtr   sojourn, fa_sum, late, ctrl;
  logic     below, ok, drop;
  DropCount cnt_inc, cnt_entry, c_sel, c_lim;
  LutAddr   lut_addr;
  InvSqrt   lut_data;
  CtrlProd  prod;
  logic [INV_SQRT_FRAC_W:0] mul;

  assign cur     = st_q[i__queue_id];
  assign sojourn = i__time_counter - i__packet_time_stamp;
  assign fa_sum  = i__time_counter + i__interval;

  assign below = i__packet_null
               | ~time_ge(sojourn, i__target)
               | (i__queue_length < MAX_PACKET);

  assign cnt_inc = (&cur.count) ? cur.count
                 : cur.count + DropCount'(1);

  // Re-entry soon after the last drop resumes near the old rate.
  assign late = (i__time_counter - cur.drop_next)
              - (i__interval << 4);
  assign cnt_entry =
    (cur.count > DropCount'(2) && late[TIME_W-1])
      ? cur.count - DropCount'(2) : DropCount'(1);

  // One ROM serves both paths: only one is taken per request.
  assign c_sel = (cur.dropping == DROPPING) ? cnt_inc : cnt_entry;
  assign c_lim = (c_sel > DropCount'(LUT_ENTRIES))
               ? DropCount'(LUT_ENTRIES) : c_sel;
  assign lut_addr = LutAddr'(c_lim - DropCount'(1));

  codel_inv_sqrt_lut u_lut (
    .addr (lut_addr),
    .data (lut_data)
  );

  // Entry 1 is stored as 0xFFFF; use exact 1.0 for count 1.
  assign mul  = (c_sel == DropCount'(1))
              ? {1'b1, {INV_SQRT_FRAC_W{1'b0}}}
              : {1'b0, lut_data};
  assign prod = CtrlProd'(i__interval) * CtrlProd'(mul);
  assign ctrl = prod[TIME_W+INV_SQRT_FRAC_W-1:INV_SQRT_FRAC_W];

  always_comb begin
    nxt  = cur;
    ok   = 1'b0;
    drop = 1'b0;
    if (below) begin
      nxt.first_above = '0;
    end else if (cur.first_above == '0) begin
      // Zero means unset, so a sum landing on 0 is nudged to 1.
      nxt.first_above = (fa_sum == '0) ? TimeCtr'(1) : fa_sum;
    end else begin
      ok = time_ge(i__time_counter, cur.first_above);
    end
    unique case (cur.dropping)
      DROPPING: begin
        if (!ok) begin
          nxt.dropping = IDLE;
        end else if (time_ge(i__time_counter, cur.drop_next)) begin
          drop          = 1'b1;
          nxt.count     = cnt_inc;
          nxt.drop_next = cur.drop_next + ctrl;
        end
      end
      IDLE: begin
        if (ok) begin
          drop          = 1'b1;
          nxt.dropping  = DROPPING;
          nxt.count     = cnt_entry;
          nxt.drop_next = i__time_counter + ctrl;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_QUEUES; i++) st_q[i] <= '0;
      o__valid    <= 1'b0;
      o__queue_id <= '0;
      o__drop     <= 1'b0;
      o__dropping <= 1'b0;
      o__count    <= '0;
    end else begin
      o__valid <= i__deq_valid;
      o__drop  <= i__deq_valid & drop;
      if (i__deq_valid) begin
        st_q[i__queue_id] <= nxt;
        o__queue_id       <= i__queue_id;
        o__dropping       <= (nxt.dropping == DROPPING);
        o__count          <= nxt.count;
      end
    end
  end
endmodule
